// File: rtl/plru_array_ctrl.sv
// -----------------------------------------------------------------------------
// plru_array_ctrl
//   Per-set 4-way tree pseudo-LRU state keeper and victim scheduler.
//   Every set holds a 3-bit tree state. Lookups return a registered victim way
//   one cycle after acceptance. Hit and fill touches go through a one-entry
//   pending register before they are written into the state array.
//
//   Tree state per set, lru[2:0]:
//     lru[0] = 1 : the last access was in ways 2/3
//     lru[1] = 1 : way1 is more recent than way0
//     lru[2] = 1 : way3 is more recent than way2
//
// Optional feature macro: PLRU_BYPASS_EN
//   defined   : lookups never stall. A lookup that hits an in-flight touch
//               sees the forwarded state (array, then pending, then incoming).
//   undefined : a lookup that hits a valid incoming or pending touch is
//               stalled (lookup_ready_o=0) and later reads the array directly.
//
// Ports:
//   clk_i           clock, all state updates on the rising edge
//   rst_n_i         synchronous active-low reset
//   lookup_valid_i  victim lookup request
//   lookup_set_i    set to look up
//   lookup_ready_o  lookup accepted this cycle when valid & ready
//   victim_valid_o  one-cycle pulse, victim result valid
//   victim_set_o    set of the returned victim
//   victim_way_o    way to evict
//   touch_valid_i   access (hit or fill) to record, always accepted
//   touch_set_i     set accessed
//   touch_way_i     way accessed
// -----------------------------------------------------------------------------
module plru_array_ctrl #(
    parameter  int NUM_SETS = 16,
    localparam int SET_W    = $clog2(NUM_SETS)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             lookup_valid_i,
    input  logic [SET_W-1:0] lookup_set_i,
    output logic             lookup_ready_o,
    output logic             victim_valid_o,
    output logic [SET_W-1:0] victim_set_o,
    output logic [1:0]       victim_way_o,
    input  logic             touch_valid_i,
    input  logic [SET_W-1:0] touch_set_i,
    input  logic [1:0]       touch_way_i
);

    // Record an access to 'way' in tree state 's'; untouched bits are kept.
    function automatic logic [2:0] plru_touch(input logic [2:0] s, input logic [1:0] way);
        logic [2:0] r;
        r = s;
        r[0] = way[1];
        if (way[1]) begin
            r[2] = way[0];
        end else begin
            r[1] = way[0];
        end
        return r;
    endfunction

    // Victim is the less recent way of the half that was not accessed last.
    function automatic logic [1:0] plru_victim(input logic [2:0] s);
        logic [1:0] v;
        if (!s[0]) begin
            v = s[2] ? 2'd2 : 2'd3;
        end else begin
            v = s[1] ? 2'd0 : 2'd1;
        end
        return v;
    endfunction

    logic [2:0]       lru_q [NUM_SETS];
    logic [2:0]       lru_d [NUM_SETS];

    logic             pend_valid_q, pend_valid_d;
    logic [SET_W-1:0] pend_set_q,   pend_set_d;
    logic [1:0]       pend_way_q,   pend_way_d;

    logic             victim_valid_q, victim_valid_d;
    logic [SET_W-1:0] victim_set_q,   victim_set_d;
    logic [1:0]       victim_way_q,   victim_way_d;

    logic             pend_hit;
    logic             touch_hit;
    logic             lookup_ready;
    logic             lookup_fire;
    logic [2:0]       lookup_state;

    assign pend_hit  = pend_valid_q  && (pend_set_q  == lookup_set_i);
    assign touch_hit = touch_valid_i && (touch_set_i == lookup_set_i);

`ifdef PLRU_BYPASS_EN
    // Forward oldest to newest: array, pending touch, incoming touch.
    always_comb begin
        lookup_state = lru_q[lookup_set_i];
        if (pend_hit) begin
            lookup_state = plru_touch(lookup_state, pend_way_q);
        end
        if (touch_hit) begin
            lookup_state = plru_touch(lookup_state, touch_way_i);
        end
        lookup_ready = rst_n_i;
    end
`else
    // No forwarding: hold the lookup off until no touch to its set is in flight.
    always_comb begin
        lookup_state = lru_q[lookup_set_i];
        lookup_ready = rst_n_i && !pend_hit && !touch_hit;
    end
`endif

    assign lookup_fire = lookup_valid_i && lookup_ready;

    // Pending touch is committed to the array at the end of its second cycle.
    always_comb begin
        lru_d = lru_q;
        if (pend_valid_q) begin
            lru_d[pend_set_q] = plru_touch(lru_q[pend_set_q], pend_way_q);
        end
    end

    always_comb begin
        pend_valid_d   = touch_valid_i;
        pend_set_d     = touch_set_i;
        pend_way_d     = touch_way_i;
        victim_valid_d = lookup_fire;
        victim_set_d   = victim_set_q;
        victim_way_d   = victim_way_q;
        if (lookup_fire) begin
            victim_set_d = lookup_set_i;
            victim_way_d = plru_victim(lookup_state);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                lru_q[i] <= 3'b000;
            end
            pend_valid_q   <= 1'b0;
            victim_valid_q <= 1'b0;
            victim_set_q   <= '0;
            victim_way_q   <= 2'b00;
        end else begin
            lru_q          <= lru_d;
            pend_valid_q   <= pend_valid_d;
            pend_set_q     <= pend_set_d;
            pend_way_q     <= pend_way_d;
            victim_valid_q <= victim_valid_d;
            victim_set_q   <= victim_set_d;
            victim_way_q   <= victim_way_d;
        end
    end

    assign lookup_ready_o = lookup_ready;
    assign victim_valid_o = victim_valid_q;
    assign victim_set_o   = victim_set_q;
    assign victim_way_o   = victim_way_q;

endmodule

// File: doc/plru_array_ctrl.md
# plru_array_ctrl

Per-set tree-PLRU state keeper and victim scheduler for the 4-way cache. It holds the 3-bit pseudo-LRU state of every set and accepts lookups from the cache controller, returning a registered victim way one cycle later. It also accepts hit and fill touches through a one-stage write pipeline, resolving read-after-write hazards between lookups and in-flight touches. It sits beside the tag/data arrays and is driven by the cache FSM.

## Interface
- NUM_SETS, 16, number of sets (power of two, ≥2)
- SET_W, $clog2(NUM_SETS), set index width (derived, not overridden)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- lookup_valid  in  1  victim lookup request
- lookup_set  in  SET_W  set to look up
- lookup_ready  out  1  lookup accepted this cycle when valid&ready
- victim_valid  out  1  one-cycle pulse, victim result valid
- victim_set  out  SET_W  set of returned victim
- victim_way  out  2  way to evict
- touch_valid  in  1  access (hit or fill) to record; always accepted
- touch_set  in  SET_W  set accessed
- touch_way  in  2  way accessed

## Operation
- State encoding per set, lru[2:0]:
  - lru[0]=1: the last access was in ways 2/3.
  - lru[1]=1: way1 is more recent than way0.
  - lru[2]=1: way3 is more recent than way2.
- Touch update (other bits unchanged):
  - way0: lru[0]=0, lru[1]=0.
  - way1: lru[0]=0, lru[1]=1.
  - way2: lru[0]=1, lru[2]=0.
  - way3: lru[0]=1, lru[2]=1.
- Victim select:
  - lru[0]=0: victim = lru[2] ? 2 : 3.
  - lru[0]=1: victim = lru[1] ? 0 : 1.
- Array: NUM_SETS×3 flops. The synchronous reset clears every set to 3'b000, giving victim way 3 for all sets.
- Touch pipeline, two stages:
  - Cycle T: a touch is captured into the pending register (pend_valid, pend_set, pend_way).
  - Cycle T+1: the pending update is applied to array[pend_set] at the edge ending T+1.
  - Back-to-back touches stream at one per cycle.
- Effective state of a set:
  - Start from the array value.
  - Then apply the pending touch if pend_set matches.
  - Then apply the incoming touch if touch_set matches.
  - Order is always oldest to newest.
- Lookup:
  - When lookup_valid&lookup_ready, the victim is computed from the state at acceptance.
  - The result is registered into victim_way and victim_set, with victim_valid=1 the next cycle.
  - There is no response backpressure. The consumer must sample victim_* in the cycle victim_valid=1.
- Hazard (lookup_set equal to a valid touch_set or pend_set): behaviour is set by Configuration.
- A lookup never modifies state. The controller issues a separate touch for the fill.

## Timing
- During rst_n=0 and the cycle it is sampled low:
  - lookup_ready=0, victim_valid=0, victim_way=2'b00, victim_set=0.
  - pend_valid=0, array all 000.
- Reset mid-operation: a pending touch and any in-flight lookup are discarded. No victim_valid follows.
- lookup_ready is combinational from rst_n, lookup_set, touch_*, and pend_*. It is 1 whenever there is no stall condition.
- Lookup latency: exactly 1 cycle from acceptance to victim_valid.
- Throughput: one lookup per cycle when there are no hazards.
- Touch latency: the array reflects the touch 2 edges after the touch is presented.
- A touch and a lookup to different sets in the same cycle do not interact.

## Configuration
- PLRU_BYPASS_EN defined:
  - lookup_ready=1 whenever rst_n=1.
  - Hazarding lookups use the forwarded effective state (pending, then incoming touch).
- PLRU_BYPASS_EN undefined:
  - Forwarding into lookups is removed.
  - lookup_ready=0 when lookup_set matches a valid touch_set or a valid pend_set. The requester holds its request.
  - The stall lasts at most 2 cycles after the last conflicting touch.
  - The lookup then reads the array directly.
- Array update and forwarding order are identical in both builds.

## Test plan
- Reset, then lookup set 5 → lookup_ready=1; next cycle victim_valid=1, victim_set=5, victim_way=3.
- Touch set 2 way 0, idle 2 cycles, then lookup set 2 → victim_way=3. Then touch set 2 way 3, idle 2, lookup → victim_way=1 (state 101).
- Touch set 7 ways 0,1,2,3 on consecutive cycles, idle 2, lookup set 7 → state 111, victim_way=0.
- Same-cycle touch set 4 way 2 with lookup set 4 (pend holds touch set 4 way 0):
  - Bypass build: accepted, victim_way=1.
  - Non-bypass build: lookup_ready=0 for 2 cycles, then accepted, victim_way=1.
- Touch set 9 way 1 with lookup set 10 in the same cycle → lookup accepted in both builds, victim_way=3, and set 9 later reads 010.
- Assert rst_n=0 while pend_valid=1 and a lookup is accepted → no victim_valid next cycle, and all sets look up victim_way=3 after release.
